// File: rtl/alu_mul_sequencer.sv
// ---------------------------------------------------------------------------
// alu_mul_sequencer
//
// Purpose:
//   Iterative signed WIDTH x WIDTH shift-add multiplier that sits in the EX
//   stage beside the ALU, together with the pipeline-stall sequencer that
//   keeps the multiply instruction in EX until its 2*WIDTH-bit product is
//   ready. Single-cycle ALU ops never touch this block. The EX result mux
//   selects result_lo/result_hi while done is high.
//
//   The operands are converted to unsigned magnitudes at issue. One
//   multiplier bit is consumed per RUN cycle. The sign is applied once to
//   the final accumulator. Latency is fixed: issue cycle, WIDTH RUN cycles,
//   and then one DONE cycle. There is no early exit on zero operands.
//
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   start        in   EX-stage instruction valid
//   alu_control  in   [5:0] decoded ALU control code of the EX instruction
//   a            in   [WIDTH-1:0] rs operand, two's complement
//   b            in   [WIDTH-1:0] rt operand, two's complement
//   flush        in   squash the EX instruction (branch/jump redirect)
//   stall        out  holds PC, IF/ID and ID/EX registers
//   busy         out  high while the shift-add loop runs
//   done         out  one-cycle pulse, result valid
//   result_lo    out  [WIDTH-1:0] low half of the product
//   result_hi    out  [WIDTH-1:0] high half of the product
// ---------------------------------------------------------------------------
module alu_mul_sequencer #(
    parameter int          WIDTH    = 32,
    parameter logic [5:0]  MUL_CODE = 6'b011000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [5:0]       alu_control,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi
);

    // Iteration counter width. A one-bit counter is used when WIDTH is 1 so
    // that the declaration stays legal.
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    // The terminal count is compared explicitly. Counter wrap-around is
    // never relied on to end the loop.
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    state_t               state_reg;
    logic [WIDTH-1:0]     mcand_reg;
    logic [WIDTH-1:0]     mplier_reg;
    logic [2*WIDTH-1:0]   acc_reg;
    logic [CW-1:0]        count_reg;
    logic                 neg_reg;
    logic                 busy_reg;
    logic                 done_reg;
    logic [WIDTH-1:0]     result_lo_reg;
    logic [WIDTH-1:0]     result_hi_reg;

    logic                 issue;
    logic [WIDTH-1:0]     mag_a;
    logic [WIDTH-1:0]     mag_b;
    logic [2*WIDTH-1:0]   shifted;
    logic [2*WIDTH-1:0]   addend;
    logic [2*WIDTH-1:0]   acc_next;
    logic [2*WIDTH-1:0]   product_next;

    // A squashed instruction never issues, even when it is a multiply.
    assign issue = start && (alu_control == MUL_CODE) && !flush;

    // Unsigned magnitudes. Negating the most negative value gives the same
    // bit pattern, and that pattern is the correct unsigned magnitude
    // (2^(WIDTH-1)).
    assign mag_a = a[WIDTH-1] ? -a : a;
    assign mag_b = b[WIDTH-1] ? -b : b;

    // The multiplicand is aligned to the weight of the multiplier bit that
    // is consumed in this cycle. The multiplier shifts right, so its bit 0
    // is always the current bit.
    assign shifted = {{WIDTH{1'b0}}, mcand_reg} << count_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 2 * WIDTH; gi++) begin : g_addend
            assign addend[gi] = mplier_reg[0] & shifted[gi];
        end
    endgenerate

    assign acc_next = acc_reg + addend;

    // The sign is applied once to the complete magnitude product. The
    // negation has the full 2*WIDTH width.
    assign product_next = neg_reg ? -acc_next : acc_next;

    // -----------------------------------------------------------------------
    // Sequencer and datapath registers.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            mcand_reg     <= '0;
            mplier_reg    <= '0;
            acc_reg       <= '0;
            count_reg     <= '0;
            neg_reg       <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            result_lo_reg <= '0;
            result_hi_reg <= '0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (issue) begin
                        mcand_reg  <= mag_a;
                        mplier_reg <= mag_b;
                        neg_reg    <= a[WIDTH-1] ^ b[WIDTH-1];
                        acc_reg    <= '0;
                        count_reg  <= '0;
                        busy_reg   <= 1'b1;
                        state_reg  <= ST_RUN;
                    end
                end

                ST_RUN: begin
                    if (flush) begin
                        // Abandon the multiply. The previous result stays
                        // visible, and no done pulse is produced.
                        busy_reg  <= 1'b0;
                        state_reg <= ST_IDLE;
                    end else begin
                        acc_reg    <= acc_next;
                        mplier_reg <= mplier_reg >> 1;
                        count_reg  <= count_reg + CNT_ONE;
                        if (count_reg == CNT_LAST) begin
                            result_lo_reg <= product_next[WIDTH-1:0];
                            result_hi_reg <= product_next[2*WIDTH-1:WIDTH];
                            busy_reg      <= 1'b0;
                            done_reg      <= 1'b1;
                            state_reg     <= ST_DONE;
                        end
                    end
                end

                ST_DONE: begin
                    // The multiply is still in EX during this cycle, so
                    // start and alu_control are deliberately ignored here.
                    state_reg <= ST_IDLE;
                end

                default: begin
                    busy_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Stall is combinational. It must rise in the issue cycle to keep the
    // multiply in EX, and it must drop in the same cycle as a flush. It is
    // also gated by rst_n so that it reads 0 for the whole reset period.
    // -----------------------------------------------------------------------
    assign stall = rst_n &
                   (((state_reg == ST_IDLE) & issue) |
                    ((state_reg == ST_RUN)  & ~flush));

    assign busy      = busy_reg;
    assign done      = done_reg;
    assign result_lo = result_lo_reg;
    assign result_hi = result_hi_reg;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_mul_sequencer
//
// Scoreboard bench. The expected 64-bit product is queued when a multiply is
// issued. A monitor pops the queue and compares on every done pulse. The
// stimulus tasks check stall, busy and done timing cycle by cycle.
// ---------------------------------------------------------------------------
module tb_alu_mul_sequencer;

    localparam int         WIDTH    = 32;
    localparam logic [5:0] MUL_CODE = 6'b011000;
    localparam logic [5:0] ADD_CODE = 6'b100000;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [5:0]       alu_control;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             stall;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result_lo;
    logic [WIDTH-1:0] result_hi;

    int          n_cmp;
    int          n_err;
    int          n_txn;
    logic [63:0] sb_q[$];
    logic [63:0] last_result;

    alu_mul_sequencer #(
        .WIDTH    (WIDTH),
        .MUL_CODE (MUL_CODE)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .alu_control (alu_control),
        .a           (a),
        .b           (b),
        .flush       (flush),
        .stall       (stall),
        .busy        (busy),
        .done        (done),
        .result_lo   (result_lo),
        .result_hi   (result_hi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    // Step to just after the next rising edge, where inputs are driven.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Signed reference product computed by the bench itself.
    function automatic logic [63:0] ref_mul(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        logic signed [63:0] sx;
        logic signed [63:0] sy;
        sx = {{32{x[WIDTH-1]}}, x};
        sy = {{32{y[WIDTH-1]}}, y};
        return sx * sy;
    endfunction

    // Scoreboard monitor: every done pulse must match the oldest queued product.
    always @(negedge clk) begin
        if (rst_n && done) begin
            n_txn++;
            if (sb_q.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                logic [63:0] exp_p;
                exp_p = sb_q.pop_front();
                $display("txn %0d: result hi=0x%h lo=0x%h expected 0x%h",
                         n_txn, result_hi, result_lo, exp_p);
                chk("result", {result_hi, result_lo}, exp_p);
            end
        end
    end

    // Run one complete multiply. When hold is set, start stays high with the
    // MUL code through the DONE cycle.
    task automatic run_mul(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                           input logic [63:0] exp_p, input bit hold);
        int n_stall;
        bit busy_ok;
        next_cycle();
        start       = 1'b1;
        alu_control = MUL_CODE;
        a           = x;
        b           = y;
        sb_q.push_back(exp_p);
        @(negedge clk);
        chk("t0_stall", {63'd0, stall}, 64'd1);
        chk("t0_busy",  {63'd0, busy},  64'd0);
        n_stall = 1;
        busy_ok = 1'b1;
        for (int t = 1; t <= WIDTH; t++) begin
            next_cycle();
            if (!hold) start = 1'b0;
            a = $urandom;
            b = $urandom;
            @(negedge clk);
            if (stall) n_stall++;
            if (!busy || done) busy_ok = 1'b0;
            if ({result_hi, result_lo} !== last_result) busy_ok = 1'b0;
        end
        next_cycle();
        @(negedge clk);
        chk("done_pulse",   {63'd0, done},  64'd1);
        chk("done_stall",   {63'd0, stall}, 64'd0);
        chk("done_busy",    {63'd0, busy},  64'd0);
        chk("stall_cycles", 64'(n_stall),   64'(WIDTH + 1));
        chk("run_window",   {63'd0, busy_ok}, 64'd1);
        next_cycle();
        start = 1'b0;
        @(negedge clk);
        chk("post_done_idle", {62'd0, busy, done}, 64'd0);
        last_result = exp_p;
    endtask

    initial begin
        n_cmp       = 0;
        n_err       = 0;
        n_txn       = 0;
        last_result = 64'd0;
        rst_n       = 1'b0;
        start       = 1'b1;
        alu_control = MUL_CODE;
        a           = 32'd7;
        b           = 32'd6;
        flush       = 1'b0;

        // Reset state. A pending MUL must not raise stall while reset is held.
        repeat (2) @(negedge clk);
        chk("reset_outputs", {60'd0, stall, busy, done, 1'b0}, 64'd0);
        chk("reset_result",  {result_hi, result_lo}, 64'd0);
        start = 1'b0;
        next_cycle();
        rst_n = 1'b1;

        // Directed vectors with constant expected products.
        run_mul(32'd7,        32'd6,        64'h00000000_0000002A, 1'b0);
        run_mul(32'hFFFFFFFD, 32'd5,        64'hFFFFFFFF_FFFFFFF1, 1'b0);
        run_mul(32'h80000000, 32'h80000000, 64'h40000000_00000000, 1'b0);
        run_mul(32'hFFFFFFFF, 32'hFFFFFFFF, 64'h00000000_00000001, 1'b0);
        run_mul(32'd0,        32'h12345678, 64'h0,                 1'b0);

        // A non-MUL code must not stall or start the sequencer.
        next_cycle();
        start       = 1'b1;
        alu_control = ADD_CODE;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("add_no_stall", {62'd0, stall, busy}, 64'd0);
            next_cycle();
        end
        start = 1'b0;

        // Flush in the issue cycle takes priority over issue.
        start       = 1'b1;
        alu_control = MUL_CODE;
        flush       = 1'b1;
        @(negedge clk);
        chk("flush_issue_stall", {63'd0, stall}, 64'd0);
        next_cycle();
        start = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        chk("flush_issue_busy", {63'd0, busy}, 64'd0);

        // Flush at T10 of a run. Nothing is queued because no result is due.
        next_cycle();
        start       = 1'b1;
        alu_control = MUL_CODE;
        a           = 32'd11;
        b           = 32'd13;
        for (int t = 1; t <= 10; t++) begin
            next_cycle();
            start = 1'b0;
        end
        flush = 1'b1;
        @(negedge clk);
        chk("flush_stall_t10", {63'd0, stall}, 64'd0);
        next_cycle();
        flush = 1'b0;
        @(negedge clk);
        chk("flush_idle_t11", {62'd0, busy, stall}, 64'd0);
        chk("flush_result_kept", {result_hi, result_lo}, last_result);
        // Issue again at T12. Completion at T45 is checked by run_mul.
        run_mul(32'hFFFFFF00, 32'd3, 64'hFFFFFFFF_FFFFFD00, 1'b0);

        // Reset at T5 of a run aborts it. No result is queued.
        next_cycle();
        start       = 1'b1;
        alu_control = MUL_CODE;
        a           = 32'd100;
        b           = 32'd100;
        for (int t = 1; t <= 5; t++) begin
            next_cycle();
            start = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        chk("midrun_reset_ctl", {61'd0, stall, busy, done}, 64'd0);
        chk("midrun_reset_res", {result_hi, result_lo}, 64'd0);
        last_result = 64'd0;
        next_cycle();
        rst_n = 1'b1;
        run_mul(32'd2, 32'd3, 64'd6, 1'b0);

        // Start held high with the MUL code through DONE gives one done pulse.
        run_mul(32'hFFFFFFF9, 32'd9, 64'hFFFFFFFF_FFFFFFC1, 1'b1);

        // Random vectors checked against the signed reference model.
        for (int i = 0; i < 3; i++) begin
            logic [WIDTH-1:0] ra;
            logic [WIDTH-1:0] rb;
            ra = $urandom;
            rb = $urandom;
            run_mul(ra, rb, ref_mul(ra, rb), 1'b0);
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_mul_sequencer.md
Name: alu_mul_sequencer

Overview:
- Iterative signed 32x32 shift-add multiplier and its pipeline-stall sequencer, placed in the EX stage beside the ALU.
- Decoded ALU control code drives it; when the code equals MUL, the block holds the pipeline until the 64-bit product is ready.
- The ALU's single-cycle ops stay combinational. The multi-cycle op is handled here, and its result is muxed onto the EX result bus using Done.

Parameters:
- WIDTH, 32, operand width; product is 2*WIDTH.
- MUL_CODE, 6'b011000, ALU control code that selects multiply.

Ports:
- Clk  input  1  clock, rising edge.
- Rst_n  input  1  asynchronous active-low reset.
- Start  input  1  EX-stage instruction valid.
- ALUControl  input  6  decoded ALU control code of the EX instruction.
- A  input  WIDTH  rs operand, two's complement.
- B  input  WIDTH  rt operand, two's complement.
- Flush  input  1  squash the EX instruction (branch/jump redirect).
- Stall  output  1  holds PC, IF/ID and ID/EX registers.
- Busy  output  1  high in RUN.
- Done  output  1  one-cycle pulse; Result valid.
- Result_Lo  output  WIDTH  low half of product (mul rd).
- Result_Hi  output  WIDTH  high half of product.

Behaviour:
- Reset (Rst_n=0, async):
  - state=IDLE.
  - Busy=0, Done=0, Result_Lo=0, Result_Hi=0, count=0.
  - Stall forced 0 while Rst_n=0.
- Issue condition: Issue = Start && ALUControl==MUL_CODE && !Flush.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - Stall = Issue (combinational), so the MUL stays in EX.
  - On Issue:
    - latch mcand=|A| and mplier=|B| as WIDTH-bit unsigned magnitudes (|-2^31| = 0x80000000).
    - latch neg = A[WIDTH-1]^B[WIDTH-1].
    - acc=0, count=0.
    - go to RUN.
  - Other codes, or Start=0: stay in IDLE, Stall=0.
- RUN (Busy=1, Stall=1):
  - Each cycle: if mplier[0], acc += mcand << count (2*WIDTH-bit add).
  - mplier >>= 1; count++.
  - After count reaches WIDTH-1 (the WIDTH-th RUN cycle), go to DONE.
  - Register Result = neg ? -acc_final : acc_final (two's complement, 2*WIDTH bits), split into Hi/Lo.
- DONE:
  - Done=1 and Stall=0 for exactly one cycle. Busy=0.
  - Next state is IDLE unconditionally.
  - Start/ALUControl are ignored in DONE, since the same MUL is still in EX.
- Result_Hi/Lo hold their value until the next completion; they never change during RUN.
- Latency:
  - Issue cycle is T0; RUN occupies T1..T(WIDTH); Done at T(WIDTH+1).
  - Stall is high T0..T(WIDTH), i.e. WIDTH+1 cycles. No early termination, so latency is fixed regardless of zero operands.
- Flush:
  - In IDLE, it suppresses Issue.
  - In RUN, next state is IDLE and Stall drops the same cycle (combinational on Flush). No Done pulse; Result unchanged.
  - In DONE, it is ignored (the result is discarded by the pipeline).
- Flush and Issue in the same cycle: Flush wins.
- Reset mid-RUN: immediate abort to IDLE with all outputs at reset values, no Done.
- Wrap-around: count is $clog2(WIDTH) bits; the terminal compare is on WIDTH-1, with no reliance on overflow.

Test Plan:
- Issue MUL, A=7, B=6:
  - Stall high 33 cycles.
  - Done pulse at T33 with Hi=0x00000000, Lo=0x0000002A.
  - Busy high T1..T32.
- A=-3 (0xFFFFFFFD), B=5 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFF1.
- A=B=0x80000000 -> Hi=0x40000000, Lo=0x00000000.
- A=0xFFFFFFFF, B=0xFFFFFFFF -> Hi=0, Lo=1.
- ALUControl=6'b100000 (ADD) with Start=1 -> Stall=0, state stays IDLE, no Done.
- Issue MUL, then Flush at T10:
  - Stall low at T10, state IDLE at T11, no Done.
  - Prior Result retained.
  - New MUL issued at T12 completes normally at T45.
- Rst_n low at T5 of a run -> all outputs 0 immediately; after release, a fresh MUL of 2*3 gives Lo=6.
- Start held high with MUL code through DONE -> exactly one Done pulse; no re-issue in the DONE cycle.
